bfnp_train_scheduler: RTL and testbench

- Queues resolved-branch outcomes from execute and sequences all predictor training writes.
- Writes go to the branch status table, the bias and perceptron tables (conv path), and the bias-free perceptron table (BF path).
- Arbitrates the shared single-port tables against fetch-stage prediction lookups; lookups always win.
- Produces the mispredict flush pulse and saturating training statistics.

---
 rtl/bfnp_train_scheduler.sv | 144 ++++++++++++++
 tb/tb_bfnp_train_scheduler.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bfnp_train_scheduler.sv
// Training scheduler for the bias-free perceptron predictor: queues resolved branches
// and sequences BST / conv / BF table writes around fetch-stage lookups.
module bfnp_train_scheduler #(
    parameter int DEPTH = 4,
    parameter int THETA = 45,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_dir,
    input  logic             req_pred,
    input  logic [8:0]       req_sum,
    input  logic [1:0]       req_status,
    input  logic             pred_busy,
    output logic             bst_wr_en,
    output logic [1:0]       bst_status_new,
    output logic             conv_wr_en,
    output logic             bf_wr_en,
    output logic             upd_dir,
    output logic             flush,
    output logic             busy,
    output logic [CNT_W-1:0] train_cnt,
    output logic [CNT_W-1:0] mispred_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    typedef struct packed {
        logic       dir;
        logic       pred;
        logic [8:0] sum;
        logic [1:0] status;
    } train_req_t;

    typedef enum logic [2:0] {IDLE, DECIDE, WR_BST, WR_CONV, WR_BF} state_t;

    train_req_t    mem [DEPTH];
    train_req_t    work;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    state_t        state, state_d;
    logic [1:0]    new_status, new_status_d;
    logic          push, pop, in_wr, train_hit;
    logic [9:0]    sum_ext, sum_abs;

    // No bypass: readiness depends on the registered count alone.
    assign req_ready = (count != FULL);
    assign push      = req_valid && req_ready;
    assign pop       = (state == IDLE) && (count != '0);
    assign busy      = (state != IDLE) || (count != '0);

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= '{dir: req_dir, pred: req_pred, sum: req_sum, status: req_status};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
        end
    end

    // Sign-extend before negating so -256 maps to 256 rather than back to itself.
    assign sum_ext   = {work.sum[8], work.sum};
    assign sum_abs   = sum_ext[9] ? (~sum_ext + 10'd1) : sum_ext;
    assign train_hit = (work.pred != work.dir) || (sum_abs <= 10'(THETA));

    always_comb begin
        state_d      = state;
        new_status_d = new_status;
        bst_wr_en    = 1'b0;
        conv_wr_en   = 1'b0;
        bf_wr_en     = 1'b0;
        unique case (state)
            IDLE: if (count != '0) state_d = DECIDE;
            DECIDE: begin
                state_d = IDLE;
                unique case (work.status)
                    2'b00: begin
                        state_d      = WR_BST;
                        new_status_d = work.dir ? 2'b01 : 2'b10;
                    end
                    2'b01: if (work.dir) begin
                        state_d      = WR_BST;
                        new_status_d = 2'b11;
                    end
                    2'b10: if (!work.dir) begin
                        state_d      = WR_BST;
                        new_status_d = 2'b11;
                    end
                    default: if (train_hit) begin
                        state_d      = WR_CONV;
                        new_status_d = 2'b11;
                    end
                endcase
            end
            WR_BST: if (!pred_busy) begin
                bst_wr_en = 1'b1;
                state_d   = IDLE;
            end
            WR_CONV: if (!pred_busy) begin
                conv_wr_en = 1'b1;
                state_d    = WR_BF;
            end
            WR_BF: if (!pred_busy) begin
                bf_wr_en = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_wr          = (state == WR_BST) || (state == WR_CONV) || (state == WR_BF);
    assign upd_dir        = in_wr && work.dir;
    assign bst_status_new = in_wr ? new_status : 2'b00;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            new_status  <= 2'b00;
            work        <= '0;
            flush       <= 1'b0;
            train_cnt   <= '0;
            mispred_cnt <= '0;
        end else begin
            state      <= state_d;
            new_status <= new_status_d;
            if (pop) work <= mem[rd_ptr];
            flush <= push && (req_pred != req_dir);
            if (push && (req_pred != req_dir) && (mispred_cnt != '1))
                mispred_cnt <= mispred_cnt + 1'b1;
            if (bf_wr_en && (train_cnt != '1))
                train_cnt <= train_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_bfnp_train_scheduler.sv
// Bench for bfnp_train_scheduler: latency vectors, stall/fill/abort sequences and
// random traffic scored against a transaction-level event model.
module tb_bfnp_train_scheduler;
    localparam int DEPTH = 4;
    localparam int THETA = 45;
    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             req_valid = 1'b0, req_ready;
    logic             req_dir = 1'b0, req_pred = 1'b0;
    logic [8:0]       req_sum = '0;
    logic [1:0]       req_status = '0;
    logic             pred_busy = 1'b0;
    logic             bst_wr_en, conv_wr_en, bf_wr_en, upd_dir, flush, busy;
    logic [1:0]       bst_status_new;
    logic [CNT_W-1:0] train_cnt, mispred_cnt;

    always #5 clk = ~clk;

    bfnp_train_scheduler #(.DEPTH(DEPTH), .THETA(THETA), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_dir(req_dir), .req_pred(req_pred), .req_sum(req_sum), .req_status(req_status),
        .pred_busy(pred_busy), .bst_wr_en(bst_wr_en), .bst_status_new(bst_status_new),
        .conv_wr_en(conv_wr_en), .bf_wr_en(bf_wr_en), .upd_dir(upd_dir), .flush(flush),
        .busy(busy), .train_cnt(train_cnt), .mispred_cnt(mispred_cnt)
    );

    int total = 0, bad = 0;
    int exp_q[$];            // expected write events: 8+new (BST), 16+dir (conv), 24+dir (BF)
    int m_train = 0, m_mis = 0;
    logic exp_flush = 1'b0;

    task automatic chk(input string nm, input int idx, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s[%0d]: got %0h want %0h", nm, idx, got, want);
        end
    endtask

    // What the predictor-training rules say a resolved branch must produce.
    function automatic void expect_events(logic [1:0] st, logic d, logic p, logic [8:0] s);
        int a;
        a = $signed(s);
        if (a < 0) a = -a;
        case (st)
            2'd0: exp_q.push_back(d ? 9 : 10);
            2'd1: if (d)  exp_q.push_back(11);
            2'd2: if (!d) exp_q.push_back(11);
            default: if (p != d || a <= THETA) begin
                exp_q.push_back(16 + int'(d));
                exp_q.push_back(24 + int'(d));
                m_train++;
            end
        endcase
    endfunction

    always @(negedge clk) begin
        int n, code, e;
        total++;
        if (flush !== exp_flush) begin
            bad++;
            $display("FAIL flush: got %b want %b", flush, exp_flush);
        end
        n = int'(bst_wr_en) + int'(conv_wr_en) + int'(bf_wr_en);
        if (n > 0) begin
            total++;
            if (n > 1 || pred_busy) begin
                bad++;
                $display("FAIL strobe_excl: got %0d strobes busy=%b want 1 strobe busy=0", n, pred_busy);
            end
            code = bst_wr_en ? 8 + int'(bst_status_new) : conv_wr_en ? 16 + int'(upd_dir) : 24 + int'(upd_dir);
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL event_order: got %0d want none", code);
            end else begin
                e = exp_q.pop_front();
                if (e != code) begin
                    bad++;
                    $display("FAIL event_order: got %0d want %0d", code, e);
                end
            end
        end
        if (rst) begin
            exp_q.delete();
            m_train = 0;
            m_mis   = 0;
        end else if (req_valid && req_ready) begin
            expect_events(req_status, req_dir, req_pred, req_sum);
            if (req_pred != req_dir) m_mis++;
        end
        exp_flush = !rst && req_valid && req_ready && (req_pred != req_dir);
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    typedef struct {
        logic [1:0] st;
        logic       d, p;
        logic [8:0] s;
        logic       bst;
        logic [1:0] nw;
        logic       trn, fl;
    } vec_t;

    function automatic vec_t mkv(logic [1:0] st, logic d, logic p, int s,
                                 logic bst, logic [1:0] nw, logic trn, logic fl);
        vec_t v;
        v.st = st; v.d = d; v.p = p; v.s = 9'(s);
        v.bst = bst; v.nw = nw; v.trn = trn; v.fl = fl;
        return v;
    endfunction

    task automatic run_vec(input vec_t v, input int idx);
        logic [7:0] bm, cm, fm, flm;
        logic [1:0] got_new;
        logic       ud_bad;
        bm = '0; cm = '0; fm = '0; flm = '0; got_new = 2'b00; ud_bad = 1'b0;
        req_status = v.st; req_dir = v.d; req_pred = v.p; req_sum = v.s; req_valid = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            bm[k] = bst_wr_en; cm[k] = conv_wr_en; fm[k] = bf_wr_en; flm[k] = flush;
            if (bst_wr_en) got_new = bst_status_new;
            if ((conv_wr_en || bf_wr_en) && upd_dir !== v.d) ud_bad = 1'b1;
            @(posedge clk);
            #1 req_valid = 1'b0;
        end
        chk("vec_bst", idx, 32'(bm), v.bst ? 32'h08 : 32'h0);
        chk("vec_conv", idx, 32'(cm), v.trn ? 32'h08 : 32'h0);
        chk("vec_bf", idx, 32'(fm), v.trn ? 32'h10 : 32'h0);
        chk("vec_flush", idx, 32'(flm), v.fl ? 32'h02 : 32'h0);
        if (v.bst) chk("vec_new", idx, 32'(got_new), 32'(v.nw));
        if (v.trn) chk("vec_upd_dir", idx, 32'(ud_bad), 32'h0);
        chk("vec_train_cnt", idx, 32'(train_cnt), 32'(m_train));
        chk("vec_mispred_cnt", idx, 32'(mispred_cnt), 32'(m_mis));
    endtask

    task automatic wait_idle(input string nm);
        pred_busy = 1'b0;
        req_valid = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (!busy) break;
        end
        chk(nm, 0, 32'(busy), 32'h0);
        chk(nm, 1, 32'(exp_q.size()), 32'h0);
    endtask

    task automatic chk_reset_state(input int idx);
        @(negedge clk);
        chk("rst_strobes", idx, {29'd0, bst_wr_en, conv_wr_en, bf_wr_en}, 32'h0);
        chk("rst_outs", idx, {28'd0, bst_status_new, upd_dir, flush}, 32'h0);
        chk("rst_ready_busy", idx, {30'd0, req_ready, busy}, 32'h2);
        chk("rst_counters", idx, {train_cnt, mispred_cnt}, 32'h0);
    endtask

    vec_t vecs[16];
    int   corner[7] = '{45, 46, -45, -46, -256, 255, 0};

    initial begin
        int conv_at, bf_at, leak;
        logic acc;
        vecs[0]  = mkv(2'd0, 1, 1,    0, 1, 2'b01, 0, 0);
        vecs[1]  = mkv(2'd0, 0, 0,    0, 1, 2'b10, 0, 0);
        vecs[2]  = mkv(2'd1, 1, 1,    0, 1, 2'b11, 0, 0);
        vecs[3]  = mkv(2'd1, 0, 0,    0, 0, 2'b00, 0, 0);
        vecs[4]  = mkv(2'd2, 0, 0,    0, 1, 2'b11, 0, 0);
        vecs[5]  = mkv(2'd2, 1, 1,    0, 0, 2'b00, 0, 0);
        vecs[6]  = mkv(2'd3, 1, 0,   20, 0, 2'b00, 1, 1);
        vecs[7]  = mkv(2'd3, 1, 1,   45, 0, 2'b00, 1, 0);
        vecs[8]  = mkv(2'd3, 1, 1,   46, 0, 2'b00, 0, 0);
        vecs[9]  = mkv(2'd3, 1, 1,  -45, 0, 2'b00, 1, 0);
        vecs[10] = mkv(2'd3, 0, 0, -256, 0, 2'b00, 0, 0);
        vecs[11] = mkv(2'd3, 1, 0, -256, 0, 2'b00, 1, 1);
        vecs[12] = mkv(2'd3, 0, 0,  255, 0, 2'b00, 0, 0);
        vecs[13] = mkv(2'd0, 1, 0,    0, 1, 2'b01, 0, 1);
        vecs[14] = mkv(2'd3, 0, 0,  -46, 0, 2'b00, 0, 0);
        vecs[15] = mkv(2'd3, 0, 0,    0, 0, 2'b00, 1, 0);

        tick(3);
        rst = 1'b0;
        chk_reset_state(0);
        @(posedge clk);
        #1;
        for (int i = 0; i < 16; i++) run_vec(vecs[i], i);

        // Stall in WR_CONV for five cycles, then release.
        pred_busy = 1'b1;
        req_status = 2'd3; req_dir = 1'b1; req_pred = 1'b0; req_sum = 9'd20; req_valid = 1'b1;
        conv_at = -1; bf_at = -1; leak = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (conv_wr_en && conv_at < 0) conv_at = k;
            if (bf_wr_en && bf_at < 0) bf_at = k;
            if (k >= 3 && k <= 7 && conv_wr_en) leak++;
            @(posedge clk);
            #1 req_valid = 1'b0;
            if (k == 7) pred_busy = 1'b0;
        end
        chk("stall_leak", 0, 32'(leak), 32'h0);
        chk("stall_conv_cycle", 0, 32'(conv_at), 32'd8);
        chk("stall_bf_cycle", 0, 32'(bf_at), 32'd9);

        // Fill the FIFO behind a stalled BST write; the 5th request must wait.
        pred_busy = 1'b1;
        req_status = 2'd0; req_dir = 1'b1; req_pred = 1'b1; req_valid = 1'b1;
        tick(1);
        req_valid = 1'b0;
        tick(3);
        for (int i = 0; i < 5; i++) begin
            req_status = 2'd0; req_dir = (i == 1 || i == 2); req_pred = req_dir; req_valid = 1'b1;
            @(negedge clk);
            chk("fill_ready", i, 32'(req_ready), (i < 4) ? 32'h1 : 32'h0);
            if (i < 4) tick(1);
        end
        tick(2);
        @(negedge clk);
        chk("fill_held", 0, 32'(req_ready), 32'h0);
        @(posedge clk);
        #1 pred_busy = 1'b0;
        acc = 1'b0;
        for (int c = 0; c < 20 && !acc; c++) begin
            @(negedge clk);
            acc = req_ready;
            @(posedge clk);
            #1;
        end
        req_valid = 1'b0;
        chk("fill_accept", 0, 32'(acc), 32'h1);
        wait_idle("fill_drain");

        // Reset while WR_CONV is stalled with three entries queued.
        @(posedge clk);
        #1 pred_busy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            req_status = (i == 0) ? 2'd3 : 2'd0;
            req_dir = 1'b1; req_pred = (i != 0); req_sum = 9'd20; req_valid = 1'b1;
            tick(1);
        end
        req_valid = 1'b0;
        @(negedge clk);
        chk("abort_busy", 0, 32'(busy), 32'h1);
        @(posedge clk);
        #1 rst = 1'b1;
        tick(1);
        rst = 1'b0;
        chk_reset_state(1);
        @(posedge clk);
        #1 pred_busy = 1'b0;
        tick(15);
        chk("abort_no_write", 0, 32'(train_cnt), 32'h0);

        // Random traffic with stalls; pointers wrap many times.
        for (int c = 0; c < 600; c++) begin
            req_valid  = 1'($urandom_range(0, 1));
            req_dir    = 1'($urandom_range(0, 1));
            req_pred   = ($urandom_range(0, 3) == 0) ? ~req_dir : req_dir;
            req_status = 2'($urandom_range(0, 3));
            req_sum    = ($urandom_range(0, 1) == 0) ? 9'($urandom_range(0, 511))
                                                     : 9'(corner[$urandom_range(0, 6)]);
            pred_busy  = ($urandom_range(0, 3) == 0);
            tick(1);
        end
        wait_idle("rand_drain");
        @(negedge clk);
        chk("rand_train_cnt", 0, 32'(train_cnt), 32'(m_train));
        chk("rand_mispred_cnt", 0, 32'(mispred_cnt), 32'(m_mis));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
